sevenseg_scan_ctrl: RTL
=======================

Name: sevenseg_scan_ctrl

Overview:
- Parametrised, time-multiplexed seven-segment display controller that drives the board's anode (AN) and segment (CA..CG, DP) pins.
- Generalises the existing fixed 8-digit driver with:
  - configurable digit count and scan rate;
  - per-digit enable and decimal point;
  - PWM brightness control;
  - tear-free frame-synchronous shadow update.
- Sits in the SoC peripheral domain on clk_core, fed from a memory-mapped register block.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (1..16).
- SCAN_DIV_LOG2, 10, log2 of clock cycles per digit slot (at least 4).
- DEAD_CYCLES, 16, anode-off cycles at the start of each slot (SEVENSEG_DEADTIME_EN only; must be less than 2^SCAN_DIV_LOG2).

Ports:
- clk, input, 1, clock (clk_core domain).
- rst, input, 1, synchronous active-high reset.
- i_data, input, 4*NUM_DIGITS, hex nibble per digit; digit k = i_data[4k+3:4k].
- i_digit_en, input, NUM_DIGITS, per-digit enable.
- i_dp, input, NUM_DIGITS, per-digit decimal point, 1 = lit.
- i_brightness, input, 4, duty select; on-time is (b+1)/16 of the slot.
- i_blank, input, 1, global blank; takes effect immediately, not frame-synchronised.
- o_an, output, NUM_DIGITS, anodes, active-low.
- o_seg, output, 7, segments {CA,CB,CC,CD,CE,CF,CG}, active-low; o_seg[6] = CA.
- o_dp, output, 1, decimal point, active-low.
- o_frame, output, 1, one-cycle pulse when the digit index wraps to 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - prescaler = 0, digit index = 0, shadow registers = 0;
  - o_an = all 1, o_seg = 7'h7F, o_dp = 1, o_frame = 0;
  - load_pending = 1.
- Prescaler:
  - SCAN_DIV_LOG2-bit free-running counter, wraps naturally.
  - On terminal count (all ones), the digit index increments.
  - Index NUM_DIGITS-1 wraps to 0, handled explicitly for non-power-of-two NUM_DIGITS.
- Shadow load:
  - i_data, i_digit_en, i_dp and i_brightness are captured into shadow registers on the index wrap cycle.
  - They are also captured on the first cycle after reset, when load_pending = 1; load_pending then clears.
  - Input changes mid-frame have no visible effect until the next frame. There is no tearing.
- o_frame is asserted on the cycle the index goes from NUM_DIGITS-1 to 0, coincident with the shadow load.
- Output pipeline: all outputs are registered, so outputs reflect the counter and index state of the previous cycle (1-cycle latency).
- Phase: phase = prescaler[SCAN_DIV_LOG2-1 -: 4].
- Anode active condition: o_an[idx] = 0 only when all of the following hold:
  - shadow enable[idx] = 1;
  - i_blank = 0;
  - phase <= shadow brightness.
  All other anodes are 1. Exactly zero or one anode is low at any time.
- Segment decode, hex with active-low patterns:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110;
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111;
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000;
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000.
- Segment blanking: when the current anode is inactive, o_seg = 7'h7F and o_dp = 1, which prevents ghosting on the slot edges.
- o_dp = ~shadow dp[idx] while the anode is active.
- NUM_DIGITS = 1: index is held at 0, and o_frame pulses every prescaler wrap.
- Reset asserted mid-slot: all state returns to reset values on the next edge; outputs are blank that same cycle.

Optional Feature:
- Macro: SEVENSEG_DEADTIME_EN.
- When defined: the anode is additionally forced inactive while prescaler < DEAD_CYCLES, giving an inter-digit dead time for slow anode transistors. The segment blanking rule above applies during dead time.
- When undefined: DEAD_CYCLES is ignored and anode timing is governed only by enable, blank and brightness.

Test Plan:
- Reset, then i_data = 32'h76543210, all enabled, b = 15, SCAN_DIV_LOG2 = 4:
  - o_an cycles FE, FD, ... 7F, each for 16 cycles;
  - o_seg follows the decode table for 0..7 in order;
  - o_frame pulses once per 128 cycles.
- Change i_data to 32'h88888888 mid-frame:
  - the old digits persist until the o_frame cycle;
  - from the next cycle, every slot shows o_seg = 0000000.
- b = 3, SCAN_DIV_LOG2 = 6:
  - each anode is low for exactly 16 of 64 cycles (phase 0..3);
  - o_seg = 7F outside that window.
- i_digit_en = 8'b1111_1110, i_dp = 8'h02:
  - slot 0 has o_an all 1 and o_seg = 7F;
  - slot 1 has o_dp = 0.
- i_blank raised mid-slot:
  - o_an goes to all 1 one cycle later;
  - the prescaler keeps running and the frame period is unchanged.
- With SEVENSEG_DEADTIME_EN, DEAD_CYCLES = 4, SCAN_DIV_LOG2 = 4, b = 15: each anode is low for cycles 4..15 of its slot only.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-synchronous shadow registers and PWM brightness.
// Optional inter-digit anode dead time is enabled by defining SEVENSEG_DEADTIME_EN.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_LOG2 = 10,
  parameter int DEAD_CYCLES   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [3:0]              i_brightness,
  input  logic                    i_blank,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("sevenseg_scan_ctrl: NUM_DIGITS must be 1..16");
  end
  if (SCAN_DIV_LOG2 < 4) begin : g_bad_div
    $error("sevenseg_scan_ctrl: SCAN_DIV_LOG2 must be at least 4");
  end
  if (DEAD_CYCLES >= (1 << SCAN_DIV_LOG2)) begin : g_bad_dead
    $error("sevenseg_scan_ctrl: DEAD_CYCLES must be below the slot length");
  end

  logic [SCAN_DIV_LOG2-1:0] prescaler;
  logic [IDX_W-1:0]         idx;
  logic                     load_pending;
  logic [4*NUM_DIGITS-1:0]  data_sh;
  logic [NUM_DIGITS-1:0]    en_sh;
  logic [NUM_DIGITS-1:0]    dp_sh;
  logic [3:0]               bright_sh;

  logic       slot_end;
  logic       wrap;
  logic [3:0] phase;
  logic       dead_ok;
  logic       an_on;
  logic [3:0] cur_nibble;
  logic       cur_en;
  logic       cur_dp;
  logic [NUM_DIGITS-1:0] an_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign slot_end = &prescaler;
  // Explicit compare so non-power-of-two digit counts wrap correctly.
  assign wrap     = slot_end && (idx == IDX_LAST);
  assign phase    = prescaler[SCAN_DIV_LOG2-1 -: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler    <= '0;
      idx          <= '0;
      load_pending <= 1'b1;
      data_sh      <= '0;
      en_sh        <= '0;
      dp_sh        <= '0;
      bright_sh    <= '0;
    end else begin
      prescaler    <= prescaler + 1'b1;
      load_pending <= 1'b0;
      if (slot_end) begin
        idx <= wrap ? '0 : idx + IDX_W'(1);
      end
      if (wrap || load_pending) begin
        data_sh   <= i_data;
        en_sh     <= i_digit_en;
        dp_sh     <= i_dp;
        bright_sh <= i_brightness;
      end
    end
  end

  always_comb begin
    cur_nibble = 4'h0;
    cur_en     = 1'b0;
    cur_dp     = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nibble = data_sh[4*k +: 4];
        cur_en     = en_sh[k];
        cur_dp     = dp_sh[k];
      end
    end
  end

`ifdef SEVENSEG_DEADTIME_EN
  assign dead_ok = (prescaler >= SCAN_DIV_LOG2'(DEAD_CYCLES));
`else
  assign dead_ok = 1'b1;
`endif

  assign an_on = cur_en && !i_blank && (phase <= bright_sh) && dead_ok;

  always_comb begin
    an_next = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (an_on && (idx == IDX_W'(k))) begin
        an_next[k] = 1'b0;
      end
    end
  end

  // Segments are blanked whenever no anode is driven to avoid ghosting at slot edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_an    <= '1;
      o_seg   <= 7'h7F;
      o_dp    <= 1'b1;
      o_frame <= 1'b0;
    end else begin
      o_an    <= an_next;
      o_seg   <= an_on ? hex_to_seg(cur_nibble) : 7'h7F;
      o_dp    <= an_on ? ~cur_dp : 1'b1;
      o_frame <= wrap;
    end
  end

endmodule
